pattern_scheduler: RTL and testbench

- Sequences the test-pattern generator: decides which image ID the pixel datapath renders and when that ID changes.
- Accepts debounced next/prev button pulses and an auto-cycle mode with a programmable dwell time in frames.
- Applies every change only on a frame boundary, so a pattern switch never tears mid-frame.
- Sits between the key debouncers / timing generator and the pixel pattern generator, in the pclk domain.

---
 rtl/pattern_scheduler_if.sv | 43 ++++
 rtl/pattern_scheduler.sv | 107 ++++++++++
 tb/tb_pattern_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scheduler_if.sv
// Purpose: control/status bundle between the pattern scheduler and its drivers/consumer.
// Latency: none, wires only.
// Backpressure: none; all requests are single-cycle pulses or levels.
interface pattern_scheduler_if #(
    parameter int ID_W    = 2,
    parameter int DWELL_W = 8
);
    logic               frame_start;
    logic               next_pulse;
    logic               prev_pulse;
    logic               auto_en;
    logic [DWELL_W-1:0] dwell_frames;
    logic [ID_W-1:0]    img_id;
    logic               switch_pulse;
    logic               pending;
    logic [DWELL_W-1:0] frame_cnt;

    // Driver side: timing generator, debouncers, mode control, pattern generator.
    modport master (
        output frame_start,
        output next_pulse,
        output prev_pulse,
        output auto_en,
        output dwell_frames,
        input  img_id,
        input  switch_pulse,
        input  pending,
        input  frame_cnt
    );

    // Scheduler side.
    modport slave (
        input  frame_start,
        input  next_pulse,
        input  prev_pulse,
        input  auto_en,
        input  dwell_frames,
        output img_id,
        output switch_pulse,
        output pending,
        output frame_cnt
    );
endinterface

// File: rtl/pattern_scheduler.sv
// Purpose: picks the image ID shown by the pattern generator; manual next/prev or timed auto-cycle.
// Latency: img_id updates at the edge ending the frame_start cycle; switch_pulse follows for one cycle.
// Backpressure: none; requests are latched (one per frame, last wins) and never stall the source.
module pattern_scheduler #(
    parameter int NUM_IMG = 4,
    parameter int ID_W    = 2,
    parameter int DWELL_W = 8
) (
    input logic                pclk,
    input logic                rst_n,
    pattern_scheduler_if.slave sch
);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_IMG - 1);
    localparam logic [DWELL_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic               pending_q, pending_d;
    logic               dir_q, dir_d;          // 1 = step +1, 0 = step -1
    logic [ID_W-1:0]    img_q, img_d;
    logic               sw_q, sw_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic               req_next;
    logic               req_prev;
    logic               req_any;
    logic               pend_eff;
    logic               dir_eff;
    logic               entering_auto;
    logic [DWELL_W-1:0] cnt_base;
    logic [DWELL_W-1:0] dwell_eff;
    logic               dwell_hit;
    logic [ID_W-1:0]    id_inc;
    logic [ID_W-1:0]    id_dec;

    // Request decode, modulo stepping and dwell comparison.
    always_comb begin
        req_next      = sch.next_pulse & ~sch.prev_pulse;
        req_prev      = sch.prev_pulse & ~sch.next_pulse;
        req_any       = req_next | req_prev;
        // A request arriving in the boundary cycle is honoured at that boundary.
        pend_eff      = pending_q | req_any;
        dir_eff       = req_any ? req_next : dir_q;
        entering_auto = (state_q == ST_MANUAL) && sch.auto_en;
        // Entering AUTO restarts the count, so the boundary sees a zero count.
        cnt_base      = entering_auto ? '0 : cnt_q;
        dwell_eff     = (sch.dwell_frames == '0) ? DWELL_W'(1) : sch.dwell_frames;
        dwell_hit     = (({1'b0, cnt_base} + (DWELL_W+1)'(1)) >= {1'b0, dwell_eff});
        id_inc        = (img_q == LAST_ID) ? '0 : img_q + ID_W'(1);
        id_dec        = (img_q == '0) ? LAST_ID : img_q - ID_W'(1);
    end

    // Next-state: mode follows auto_en; frame boundary applies manual step, auto step or count.
    always_comb begin
        state_d   = sch.auto_en ? ST_AUTO : ST_MANUAL;
        pending_d = pend_eff;
        dir_d     = dir_eff;
        img_d     = img_q;
        cnt_d     = cnt_base;
        sw_d      = 1'b0;

        if (sch.frame_start) begin
            if (pend_eff) begin
                img_d     = dir_eff ? id_inc : id_dec;
                pending_d = 1'b0;
                cnt_d     = '0;
            end else if ((state_d == ST_AUTO) && dwell_hit) begin
                img_d = id_inc;
                cnt_d = '0;
            end else begin
                cnt_d = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + DWELL_W'(1);
            end
            // Pulse only on a real change; a single-image build never pulses.
            sw_d = (img_d != img_q);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q   <= ST_MANUAL;
            pending_q <= 1'b0;
            dir_q     <= 1'b0;
            img_q     <= '0;
            sw_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dir_q     <= dir_d;
            img_q     <= img_d;
            sw_q      <= sw_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sch.img_id       = img_q;
    assign sch.switch_pulse = sw_q;
    assign sch.pending      = pending_q;
    assign sch.frame_cnt    = cnt_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Purpose: directed bench for pattern_scheduler with a queue-based switch scoreboard.
// Latency: expects img_id/switch_pulse one edge after the frame_start cycle.
// Backpressure: none exercised; DUT has no stall path.
module tb_pattern_scheduler;

    logic pclk = 1'b0;
    logic rst_n;

    pattern_scheduler_if #(.ID_W(2), .DWELL_W(8)) bus ();

    pattern_scheduler #(.NUM_IMG(4), .ID_W(2), .DWELL_W(8)) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .sch   (bus)
    );

    always #5 pclk = ~pclk;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    bit in_rst      = 1'b1;
    bit fs_q        = 1'b0;
    int last_img    = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // frame_start as sampled by the DUT at each edge.
    always @(posedge pclk) fs_q <= bus.frame_start;

    // Monitor: every switch_pulse pops one expected ID; any other change of img_id is an error.
    always @(negedge pclk) begin
        if (in_rst) begin
            last_img = int'(bus.img_id);
        end else begin
            if (bus.switch_pulse) begin
                check("switch_after_frame_start", int'(fs_q), 1);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_switch: got img_id %0d expected no switch at %0t",
                             bus.img_id, $time);
                end else begin
                    check("switch_img_id", int'(bus.img_id), exp_q.pop_front());
                end
            end else if (int'(bus.img_id) != last_img) begin
                vectors++;
                miscompares++;
                $display("FAIL silent_change: got img_id %0d expected %0d (no switch_pulse) at %0t",
                         bus.img_id, last_img, $time);
            end
            last_img = int'(bus.img_id);
        end
    end

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_next();
        bus.next_pulse = 1'b1;
        cyc();
        bus.next_pulse = 1'b0;
    endtask

    task automatic pulse_prev();
        bus.prev_pulse = 1'b1;
        cyc();
        bus.prev_pulse = 1'b0;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        cyc();
        bus.frame_start = 1'b0;
        idle(8);
    endtask

    task automatic next_then_frame(input int exp_id);
        pulse_next();
        exp_q.push_back(exp_id);
        frame();
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.frame_start  = 1'b0;
        bus.next_pulse   = 1'b0;
        bus.prev_pulse   = 1'b0;
        bus.auto_en      = 1'b0;
        bus.dwell_frames = 8'd3;
        idle(3);
        rst_n = 1'b1;
        check("reset_img_id", int'(bus.img_id), 0);
        check("reset_pending", int'(bus.pending), 0);
        check("reset_frame_cnt", int'(bus.frame_cnt), 0);
        check("reset_switch_pulse", int'(bus.switch_pulse), 0);
        cyc();
        in_rst = 1'b0;

        // 1: manual next, held pending until the boundary.
        idle(5);
        pulse_next();
        check("t1_pending_set", int'(bus.pending), 1);
        idle(20);
        check("t1_pending_held", int'(bus.pending), 1);
        check("t1_img_before", int'(bus.img_id), 0);
        idle(18);
        exp_q.push_back(1);
        frame();
        check("t1_pending_clear", int'(bus.pending), 0);
        check("t1_cnt_zero", int'(bus.frame_cnt), 0);
        frame();
        check("t1_cnt_inc", int'(bus.frame_cnt), 1);

        // 2: wrap-around both directions.
        next_then_frame(2);
        next_then_frame(3);
        next_then_frame(0);
        check("t2_wrap_up", int'(bus.img_id), 0);
        pulse_prev();
        exp_q.push_back(3);
        frame();
        check("t2_wrap_down", int'(bus.img_id), 3);
        next_then_frame(0);

        // 3: simultaneous next/prev ignored; next then prev gives one -1 step.
        bus.next_pulse = 1'b1;
        bus.prev_pulse = 1'b1;
        cyc();
        bus.next_pulse = 1'b0;
        bus.prev_pulse = 1'b0;
        check("t3_both_ignored", int'(bus.pending), 0);
        frame();
        check("t3_no_step", int'(bus.img_id), 0);
        check("t3_cnt", int'(bus.frame_cnt), 1);
        pulse_next();
        idle(2);
        pulse_prev();
        exp_q.push_back(3);
        frame();
        check("t3_last_wins", int'(bus.img_id), 3);

        // 4: auto cycle, dwell 3 then dwell 0.
        frame();
        check("t4_cnt_manual", int'(bus.frame_cnt), 1);
        bus.auto_en = 1'b1;
        cyc();
        check("t4_cnt_cleared_on_auto", int'(bus.frame_cnt), 0);
        frame();
        check("t4_cnt1", int'(bus.frame_cnt), 1);
        frame();
        check("t4_cnt2", int'(bus.frame_cnt), 2);
        exp_q.push_back(0);
        frame();
        check("t4_cnt_after_step", int'(bus.frame_cnt), 0);
        frame();
        frame();
        exp_q.push_back(1);
        frame();
        bus.dwell_frames = 8'd0;
        exp_q.push_back(2);
        frame();
        exp_q.push_back(3);
        frame();
        check("t4_dwell0_cnt", int'(bus.frame_cnt), 0);

        // 5: manual request in auto restarts the dwell; request coincident with frame_start.
        bus.dwell_frames = 8'd3;
        frame();
        check("t5_cnt1", int'(bus.frame_cnt), 1);
        pulse_next();
        check("t5_pending", int'(bus.pending), 1);
        exp_q.push_back(0);
        frame();
        check("t5_cnt_restart", int'(bus.frame_cnt), 0);
        frame();
        frame();
        check("t5_no_early_step", int'(bus.img_id), 0);
        exp_q.push_back(1);
        frame();
        bus.next_pulse  = 1'b1;
        bus.frame_start = 1'b1;
        exp_q.push_back(2);
        cyc();
        bus.next_pulse  = 1'b0;
        bus.frame_start = 1'b0;
        check("t5_same_cycle_pending", int'(bus.pending), 0);
        check("t5_same_cycle_cnt", int'(bus.frame_cnt), 0);
        idle(8);
        frame();
        bus.auto_en = 1'b0;
        cyc();
        check("t5_cnt_hold_on_manual", int'(bus.frame_cnt), 1);
        frame();
        check("t5_manual_cnt", int'(bus.frame_cnt), 2);

        // 6: reset glitch between edges is ignored; sampled reset drops the pending request.
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        cyc();
        check("t6_glitch_img", int'(bus.img_id), 2);
        pulse_next();
        check("t6_pending", int'(bus.pending), 1);
        in_rst = 1'b1;
        rst_n  = 1'b0;
        cyc();
        rst_n  = 1'b1;
        check("t6_rst_img", int'(bus.img_id), 0);
        check("t6_rst_pending", int'(bus.pending), 0);
        check("t6_rst_cnt", int'(bus.frame_cnt), 0);
        cyc();
        in_rst = 1'b0;
        frame();
        check("t6_no_step_after_rst", int'(bus.img_id), 0);
        check("t6_switch_low", int'(bus.switch_pulse), 0);
        next_then_frame(1);

        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
